// File: rtl/lab7_io_responder.sv
// Memory-mapped I/O responder: LED write register, synchronized switch read, sticky key-event status.
// Optional IO_KEY_COUNT_EN adds an 8-bit key-event counter returned in read_data[15:8] on KEY_ADDR reads.
module lab7_io_responder #(
  parameter logic [8:0] LED_ADDR = 9'h100,
  parameter logic [8:0] SW_ADDR  = 9'h140,
  parameter logic [8:0] KEY_ADDR = 9'h150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_valid,
  input  logic [9:0]  SW,
  input  logic [3:1]  KEY,
  output logic [7:0]  LEDR
);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  cmd_e        cmd;
  logic [9:0]  sw_meta, sw_sync;
  logic [2:0]  key_meta, key_sync, key_prev;
  logic [2:0]  key_fall;
  logic [2:0]  key_evt;
  logic [7:0]  cnt_field;
  logic        rd_sw, rd_key, wr_led;
  logic [15:0] next_read_data;
  logic        next_read_valid;
  logic        unused_wdata;

  assign cmd          = cmd_e'(mem_cmd);
  assign unused_wdata = ^write_data[15:8];

  assign rd_sw  = (cmd == CMD_READ)  && (mem_addr == SW_ADDR);
  assign rd_key = (cmd == CMD_READ)  && (mem_addr == KEY_ADDR);
  assign wr_led = (cmd == CMD_WRITE) && (mem_addr == LED_ADDR);

  // Synchronizers reset to the idle level so reset release cannot look like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      key_meta <= '1;
      key_sync <= '1;
      key_prev <= '1;
    end else begin
      sw_meta  <= SW;
      sw_sync  <= sw_meta;
      key_meta <= KEY;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  // Buttons are active-low: a press is a 1->0 transition of the synchronized level.
  assign key_fall = key_prev & ~key_sync;

  // A clearing read and a new edge in the same cycle: the edge is OR-ed in after the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_evt <= '0;
    end else begin
      key_evt <= (rd_key ? 3'b000 : key_evt) | key_fall;
    end
  end

`ifdef IO_KEY_COUNT_EN
  logic [7:0] key_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_cnt <= '0;
    end else begin
      key_cnt <= key_cnt + 8'(key_fall[0]) + 8'(key_fall[1]) + 8'(key_fall[2]);
    end
  end

  assign cnt_field = key_cnt;
`else
  assign cnt_field = '0;
`endif

  always_comb begin
    next_read_data  = '0;
    next_read_valid = 1'b0;
    if (rd_sw) begin
      next_read_data  = {6'b000000, sw_sync};
      next_read_valid = 1'b1;
    end else if (rd_key) begin
      next_read_data  = {cnt_field, 5'b00000, key_evt};
      next_read_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      LEDR       <= '0;
    end else begin
      read_data  <= next_read_data;
      read_valid <= next_read_valid;
      if (wr_led) begin
        LEDR <= write_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_lab7_io_responder.sv
// Directed self-checking bench for lab7_io_responder; expectations are hand-computed constants
// plus a bench-side key-event counter (active only when IO_KEY_COUNT_EN is defined).
module tb_lab7_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic [9:0]  SW;
  logic [3:1]  KEY;
  logic [7:0]  LEDR;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [7:0]  exp_cnt = 8'h00;
  logic [7:0]  cnt_before;

  always #5 clk = ~clk;

  lab7_io_responder #(
    .LED_ADDR(9'h100),
    .SW_ADDR (9'h140),
    .KEY_ADDR(9'h150)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .write_data(write_data),
    .read_data (read_data),
    .read_valid(read_valid),
    .SW        (SW),
    .KEY       (KEY),
    .LEDR      (LEDR)
  );

  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key_word(input logic [7:0] cnt, input logic [2:0] evt);
    logic [7:0] hi;
`ifdef IO_KEY_COUNT_EN
    hi = cnt;
`else
    hi = 8'h00;
`endif
    return {hi, 5'b00000, evt};
  endfunction

  task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
  endtask

  initial begin
    reset = 1'b1;
    SW    = 10'h000;
    KEY   = 3'b111;
    bus(2'b00, 9'h000, 16'h0000);
    tick(2);
    reset = 1'b0;
    tick();
    check("rst_ledr", {8'h00, LEDR}, 16'h0000);
    check("rst_rv", {15'h0, read_valid}, 16'h0000);
    check("rst_rd", read_data, 16'h0000);

    bus(2'b10, 9'h100, 16'hA5C3); tick();
    check("led_write", {8'h00, LEDR}, 16'h00C3);
    bus(2'b10, 9'h140, 16'hFFFF); tick();
    check("wr_sw_noeff", {8'h00, LEDR}, 16'h00C3);
    bus(2'b10, 9'h150, 16'hFFFF); tick();
    check("wr_key_noeff", {8'h00, LEDR}, 16'h00C3);
    bus(2'b00, 9'h000, 16'h0000);

    SW = 10'h2AB; tick(3);
    bus(2'b01, 9'h140, 16'h0000); tick();
    check("sw_rv", {15'h0, read_valid}, 16'h0001);
    check("sw_rd", read_data, 16'h02AB);
    bus(2'b01, 9'h1FF, 16'h0000); tick();
    check("unmap_rv", {15'h0, read_valid}, 16'h0000);
    check("unmap_rd", read_data, 16'h0000);
    bus(2'b11, 9'h140, 16'h0000); tick();
    check("cmd11_rv", {15'h0, read_valid}, 16'h0000);
    check("cmd11_rd", read_data, 16'h0000);
    bus(2'b00, 9'h000, 16'h0000);

    // Back-to-back reads, one response per cycle.
    SW = 10'h3FF; tick(3);
    bus(2'b01, 9'h140, 16'h0000); tick();
    check("b2b_sw0", read_data, 16'h03FF);
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("b2b_key", read_data, key_word(exp_cnt, 3'b000));
    check("b2b_key_rv", {15'h0, read_valid}, 16'h0001);
    bus(2'b01, 9'h140, 16'h0000); tick();
    check("b2b_sw1", read_data, 16'h03FF);
    check("b2b_sw1_rv", {15'h0, read_valid}, 16'h0001);
    bus(2'b00, 9'h000, 16'h0000); tick();
    check("none_rv", {15'h0, read_valid}, 16'h0000);

    // KEY[2] pulse -> key_evt[1], read clears.
    KEY = 3'b101; tick(5);
    KEY = 3'b111; tick(3);
    exp_cnt = exp_cnt + 8'd1;
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("key2_first", read_data, key_word(exp_cnt, 3'b010));
    tick();
    check("key2_second", read_data, key_word(exp_cnt, 3'b000));
    bus(2'b00, 9'h000, 16'h0000);

    // KEY[3] edge lands on key_evt at the same edge as a clearing read.
    KEY = 3'b011; tick(2);
    cnt_before = exp_cnt;
    bus(2'b01, 9'h150, 16'h0000); tick();
    exp_cnt = exp_cnt + 8'd1;
    check("race_read", read_data, key_word(cnt_before, 3'b000));
    tick();
    check("race_next", read_data, key_word(exp_cnt, 3'b100));
    bus(2'b00, 9'h000, 16'h0000);
    tick(4);
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("held_once", read_data, key_word(exp_cnt, 3'b000));
    bus(2'b00, 9'h000, 16'h0000);
    KEY = 3'b111; tick(4);

    // KEY[3] and KEY[2] pressed together.
    KEY = 3'b001; tick(4);
    KEY = 3'b111; tick(4);
    exp_cnt = exp_cnt + 8'd2;
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("dual_press", read_data, key_word(exp_cnt, 3'b110));
    bus(2'b00, 9'h000, 16'h0000);

    // Commands coincident with reset are discarded.
    reset = 1'b1;
    bus(2'b10, 9'h100, 16'h005A); tick();
    check("rst_wr_ledr", {8'h00, LEDR}, 16'h0000);
    bus(2'b01, 9'h140, 16'h0000); tick();
    check("rst_rd_rv", {15'h0, read_valid}, 16'h0000);
    check("rst_rd_rd", read_data, 16'h0000);
    reset = 1'b0;
    exp_cnt = 8'h00;
    bus(2'b00, 9'h000, 16'h0000); tick();
    check("post_rst_rv", {15'h0, read_valid}, 16'h0000);
    check("post_rst_ledr", {8'h00, LEDR}, 16'h0000);

    // 257 KEY[1] presses: counter wraps 255->0 and ends at 1.
    for (int unsigned p = 0; p < 257; p++) begin
      KEY = 3'b110; tick(3);
      KEY = 3'b111; tick(3);
      exp_cnt = exp_cnt + 8'd1;
    end
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("cnt_wrap", read_data, key_word(exp_cnt, 3'b001));
    check("cnt_wrap_rv", {15'h0, read_valid}, 16'h0001);
    bus(2'b01, 9'h150, 16'h0000); tick();
    check("cnt_no_clear", read_data, key_word(exp_cnt, 3'b000));
    bus(2'b00, 9'h000, 16'h0000); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lab7_io_responder.md
LAB7_IO_RESPONDER -- requirements
Module: lab7_io_responder

Interface
REQ-001 Parameter LED_ADDR, default 9'h100: address of the LED output register (write-only).
REQ-002 Parameter SW_ADDR, default 9'h140: address of the switch input register (read-only).
REQ-003 Parameter KEY_ADDR, default 9'h150: address of the key-event status register (read, clear-on-read).
REQ-004 clk  input  1: single system clock; all state SHALL update on the rising edge only.
REQ-005 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 mem_cmd  input  2: bus command from the CPU; 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 treated as NONE.
REQ-007 mem_addr  input  9: bus address.
REQ-008 write_data  input  16: bus write data.
REQ-009 read_data  output  16: registered read data.
REQ-010 read_valid  output  1: high for exactly one cycle when read_data holds a response.
REQ-011 SW  input  10: raw slide switches, asynchronous to clk.
REQ-012 KEY  input  3: raw push buttons KEY[3:1], active-low, asynchronous to clk.
REQ-013 LEDR  output  8: LED register contents.

Function
REQ-014 SW and KEY SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 A falling edge on a synchronized KEY bit SHALL set the matching sticky bit key_evt[2:0] one cycle after the edge is seen at the synchronizer output.
REQ-016 WRITE with mem_addr==LED_ADDR SHALL load LEDR <= write_data[7:0] at that edge; LEDR SHALL be visible the following cycle.
REQ-017 WRITE to any other address, including SW_ADDR and KEY_ADDR, SHALL have no effect.
REQ-018 READ of SW_ADDR SHALL give read_data = {6'b0, synchronized SW} and read_valid=1 in the next cycle (latency 1).
REQ-019 READ of KEY_ADDR SHALL give read_data[2:0]=key_evt and read_data[7:3]=0 with latency 1, and SHALL clear key_evt at the same edge.
REQ-020 If a new key edge and a clearing read of KEY_ADDR fall in the same cycle, the new edge SHALL win: its bit stays set, and the read returns the pre-edge value.
REQ-021 READ of any unmapped address, and any NONE cycle, SHALL give read_valid=0 and read_data=16'h0000 in the next cycle.
REQ-022 Back-to-back READs SHALL each produce one valid response, one cycle later, with no bubbles.
REQ-023 A KEY held low SHALL set its event bit only once; the bit can be set again only after a release.

Reset
REQ-024 While reset=1 at an edge: LEDR=8'h00, read_data=16'h0000, read_valid=0, key_evt=3'b000, press counter=0.
REQ-025 Synchronizer flops SHALL reset to the idle level (SW 0, KEY 1) so that reset release produces no spurious key event.
REQ-026 A READ or WRITE coincident with reset SHALL be discarded: no response and no register change.

Configuration
REQ-027 With macro IO_KEY_COUNT_EN defined, an 8-bit counter SHALL add one on each key event (any bit; two or three simultaneous bits add the number of bits set), SHALL wrap 255->0, and SHALL be returned in read_data[15:8] on KEY_ADDR reads; reading SHALL NOT clear the counter.
REQ-028 Without IO_KEY_COUNT_EN, no counter SHALL exist and read_data[15:8] on KEY_ADDR reads SHALL be 8'h00.

Verification
REQ-029 Reset 2 cycles, then NONE -> LEDR=0x00, read_valid=0, read_data=0x0000.
REQ-030 WRITE LED_ADDR with 0xA5C3 -> LEDR=0xC3 in the next cycle; WRITE 0x140 with 0xFFFF -> LEDR stays 0xC3.
REQ-031 SW=10'h2AB held 3 cycles, then READ 0x140 -> next cycle read_valid=1, read_data=0x02AB; READ 0x1FF -> read_valid=0, read_data=0x0000.
REQ-032 KEY[2] pulsed low for 5 cycles, then READ 0x150 twice -> first read_data[2:0]=3'b010, second 3'b000.
REQ-033 Key edge timed to reach key_evt on the same edge as a clearing READ 0x150 -> that read returns 0, the next read returns the bit set.
REQ-034 With IO_KEY_COUNT_EN, 257 KEY[1] presses -> read_data[15:8]=0x01; without the macro -> 0x00.
